wh_bram_packer: RTL and testbench
=================================

// Module: wh_bram_packer
// PURPOSE
// - Upstream feeder of the DMVM stage. Packs the streamed WH feature matrix into WH BRAM words and writes them through BRAM port A.
// - Word layout, MSB to LSB: {feat[0], feat[1], ..., feat[NUM_FEATURES-1], nb_size, src_flag}.
// - One word per node row. Rows are grouped by neighbourhood; the first row of each group is the source node and carries src_flag=1.
// - Pulses wh_ready_o when a full frame is in BRAM; that pulse drives the DMVM pe_ready_i.
// PARAMETERS
// - DATA_WIDTH       8     width of one feature element
// - NUM_FEATURES     16    feature elements per row
// - NUM_OF_NODES     168   max neighbourhood size; sets the nb_size field range
// - BRAM_ADDR_WIDTH  32    width of WH_BRAM_addra
// - BRAM_DEPTH       1024  writable words; valid addresses are 0..BRAM_DEPTH-1
// - NUM_NODE_WIDTH   $clog2(NUM_OF_NODES)  (localparam)
// - WH_BRAM_WIDTH    DATA_WIDTH*NUM_FEATURES+NUM_NODE_WIDTH+1  (localparam)
// PORTS
// - clk            in   1                rising-edge clock
// - rst            in   1                synchronous, active-high reset
// - start_i        in   1                begin a new frame (sampled in IDLE only)
// - nb_valid_i     in   1                neighbourhood header valid
// - nb_size_i      in   NUM_NODE_WIDTH   rows in this neighbourhood
// - nb_last_i      in   1                this header is the last of the frame
// - nb_ready_o     out  1                header accepted when nb_valid_i && nb_ready_o
// - feat_valid_i   in   1                feature element valid
// - feat_data_i    in   DATA_WIDTH       feature element; feat[0] arrives first
// - feat_ready_o   out  1                element accepted when feat_valid_i && feat_ready_o
// - WH_BRAM_din    out  WH_BRAM_WIDTH    packed word
// - WH_BRAM_ena    out  1                port A enable
// - WH_BRAM_wea    out  1                port A write enable
// - WH_BRAM_addra  out  BRAM_ADDR_WIDTH  write address
// - row_count_o    out  BRAM_ADDR_WIDTH  rows written in the current frame
// - wh_ready_o     out  1                one-cycle frame-done pulse
// - overflow_o     out  1                sticky; a write was dropped because BRAM was full
// - err_o          out  1                one-cycle pulse; header with nb_size_i==0 received
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; address and counters 0. Reset mid-frame abandons the frame and issues no write.
// - FSM states:
//   - IDLE -> HDR on start_i. Clears address, row_count_o and overflow_o.
//   - HDR: nb_ready_o=1. On handshake, latch nb_size and nb_last, set row_idx=0, go to COLLECT.
//     - nb_size_i==0: pulse err_o, stay in HDR. If nb_last_i=1 on that header, go to DONE instead.
//   - COLLECT: feat_ready_o=1. Shift each accepted element into the row register. The 16th accepted element moves to WRITE on the next cycle.
//   - WRITE: one cycle with ena=wea=1, din=packed word, addra=current address.
//     - src_flag = (row_idx==0).
//     - After the write: address++ and row_count_o++.
//     - If row_idx==nb_size-1: go to HDR, or DONE if nb_last is set. Otherwise row_idx++ and return to COLLECT.
//   - DONE: wh_ready_o=1 for exactly one cycle, then IDLE.
// - Latency: the write occurs the cycle after the last element's handshake. Throughput is NUM_FEATURES+1 cycles per row.
// - feat_ready_o and nb_ready_o are never both 1. Both are 0 in IDLE, WRITE and DONE.
// - Full BRAM: once the address reaches BRAM_DEPTH, WRITE drives ena=wea=0 and sets overflow_o. Row and address counters stop. Framing continues normally.
// - start_i outside IDLE is ignored. feat_valid_i outside COLLECT is not consumed.
// - nb_size_i is stored unmodified in every row of its group.
// CONFIGURATION
// - WH_PACKER_CHECKSUM_EN defined:
//   - Adds output checksum_o [31:0]: wrapping sum of all accepted feat_data_i (zero-extended) in the current frame.
//   - Cleared on start_i. Stable and valid while wh_ready_o=1 and until the next start.
// - Not defined: no checksum_o port and no adder logic.
// TESTING
// - Two groups: header size 5 with rows of all 1/2/3/4/5, then size 5 with last=1 and rows 1/2/3/4/1.
//   -> addr 0..9 written; words at 0 and 5 have src_flag=1; nb field=5 in all rows; wh_ready_o pulses once; row_count_o=10.
// - feat_valid_i toggled every other cycle -> identical BRAM contents; each write is exactly 1 cycle after the 16th handshake.
// - Header nb_size_i=0, last=0, then size 1 with last=1 -> err_o pulses once; 1 word at addr 0 with src_flag=1.
// - BRAM_DEPTH=4, one group of 6 rows -> addr 0..3 written; overflow_o=1; row_count_o=4; wh_ready_o still pulses.
// - rst asserted after 8 elements of row 2 -> no further writes; all outputs 0. A new start writes from addr 0.
// - WH_PACKER_CHECKSUM_EN on, first scenario -> checksum_o=16*(1+2+3+4+5+1+2+3+4+1)=416 at wh_ready_o.

Source files
------------

// File: rtl/wh_bram_packer.sv
// wh_bram_packer: packs streamed WH feature rows into BRAM port-A words, one word per node row.
// Build option WH_PACKER_CHECKSUM_EN adds checksum_o, a per-frame sum of accepted feature elements.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start_i
// S_HDR     | accepting a neighbourhood header
// S_COLLECT | shifting feature elements of one row into the row register
// S_WRITE   | single-cycle BRAM write of the packed row (dropped if full)
// S_DONE    | one-cycle frame-done pulse on wh_ready_o
module wh_bram_packer #(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_FEATURES    = 16,
  parameter int NUM_OF_NODES    = 168,
  parameter int BRAM_ADDR_WIDTH = 32,
  parameter int BRAM_DEPTH      = 1024,
  localparam int NUM_NODE_WIDTH = $clog2(NUM_OF_NODES),
  localparam int WH_BRAM_WIDTH  = DATA_WIDTH*NUM_FEATURES+NUM_NODE_WIDTH+1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       nb_valid_i,
  input  logic [NUM_NODE_WIDTH-1:0]  nb_size_i,
  input  logic                       nb_last_i,
  output logic                       nb_ready_o,
  input  logic                       feat_valid_i,
  input  logic [DATA_WIDTH-1:0]      feat_data_i,
  output logic                       feat_ready_o,
  output logic [WH_BRAM_WIDTH-1:0]   WH_BRAM_din,
  output logic                       WH_BRAM_ena,
  output logic                       WH_BRAM_wea,
  output logic [BRAM_ADDR_WIDTH-1:0] WH_BRAM_addra,
  output logic [BRAM_ADDR_WIDTH-1:0] row_count_o,
  output logic                       wh_ready_o,
  output logic                       overflow_o,
  output logic                       err_o
`ifdef WH_PACKER_CHECKSUM_EN
  ,
  output logic [31:0]                checksum_o
`endif
);

  localparam int ROW_WIDTH  = DATA_WIDTH*NUM_FEATURES;
  localparam int FEAT_CNT_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam logic [FEAT_CNT_W-1:0]      LAST_FEAT = FEAT_CNT_W'(NUM_FEATURES-1);
  localparam logic [BRAM_ADDR_WIDTH-1:0] DEPTH_LIM = BRAM_ADDR_WIDTH'(BRAM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_COLLECT = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                      state_q, state_d;
  logic [ROW_WIDTH-1:0]        row_q;
  logic [NUM_NODE_WIDTH-1:0]   nb_size_q;
  logic                        nb_last_q;
  logic [NUM_NODE_WIDTH-1:0]   row_idx_q;
  logic [FEAT_CNT_W-1:0]       feat_cnt_q;
  logic [BRAM_ADDR_WIDTH-1:0]  addr_q;
  logic [BRAM_ADDR_WIDTH-1:0]  row_count_q;
  logic                        overflow_q;

  logic bram_full;
  logic last_row;
  logic last_feat;
  logic wr_en;

  assign bram_full = (addr_q >= DEPTH_LIM);
  assign last_row  = (row_idx_q == (nb_size_q - NUM_NODE_WIDTH'(1)));
  assign last_feat = (feat_cnt_q == LAST_FEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      nb_size_q   <= '0;
      nb_last_q   <= 1'b0;
      row_idx_q   <= '0;
      feat_cnt_q  <= '0;
      addr_q      <= '0;
      row_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q      <= '0;
            row_count_q <= '0;
            overflow_q  <= 1'b0;
          end
        end
        S_HDR: begin
          // zero-size headers are rejected and leave the latched group untouched
          if (nb_valid_i && (nb_size_i != '0)) begin
            nb_size_q  <= nb_size_i;
            nb_last_q  <= nb_last_i;
            row_idx_q  <= '0;
            feat_cnt_q <= '0;
          end
        end
        S_COLLECT: begin
          if (feat_valid_i) begin
            row_q      <= {row_q[ROW_WIDTH-DATA_WIDTH-1:0], feat_data_i};
            feat_cnt_q <= feat_cnt_q + FEAT_CNT_W'(1);
          end
        end
        S_WRITE: begin
          if (bram_full) begin
            overflow_q <= 1'b1;
          end else begin
            addr_q      <= addr_q + BRAM_ADDR_WIDTH'(1);
            row_count_q <= row_count_q + BRAM_ADDR_WIDTH'(1);
          end
          feat_cnt_q <= '0;
          if (!last_row) row_idx_q <= row_idx_q + NUM_NODE_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    nb_ready_o    = 1'b0;
    feat_ready_o  = 1'b0;
    wr_en         = 1'b0;
    wh_ready_o    = 1'b0;
    err_o         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_HDR;
      end
      S_HDR: begin
        nb_ready_o = 1'b1;
        if (nb_valid_i) begin
          if (nb_size_i == '0) begin
            err_o = 1'b1;
            if (nb_last_i) state_d = S_DONE;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        feat_ready_o = 1'b1;
        if (feat_valid_i && last_feat) state_d = S_WRITE;
      end
      S_WRITE: begin
        wr_en = !bram_full;
        if (last_row) state_d = nb_last_q ? S_DONE : S_HDR;
        else          state_d = S_COLLECT;
      end
      S_DONE: begin
        wh_ready_o = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign WH_BRAM_ena   = wr_en;
  assign WH_BRAM_wea   = wr_en;
  assign WH_BRAM_din   = wr_en ? {row_q, nb_size_q, (row_idx_q == '0)} : '0;
  assign WH_BRAM_addra = addr_q;
  assign row_count_o   = row_count_q;
  assign overflow_o    = overflow_q;

`ifdef WH_PACKER_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else if ((state_q == S_IDLE) && start_i) begin
      checksum_q <= '0;
    end else if ((state_q == S_COLLECT) && feat_valid_i) begin
      checksum_q <= checksum_q + 32'(feat_data_i);
    end
  end

  assign checksum_o = checksum_q;
`endif

endmodule

// File: tb/tb_wh_bram_packer.sv
// Self-checking bench for wh_bram_packer: two instances (deep and 4-word BRAM) share one stimulus
// stream and are compared every cycle against a transaction-level model; directed frames pin the model.
module tb_wh_bram_packer;
  localparam int DW = 8;
  localparam int NF = 16;
  localparam int NNW = 8;
  localparam int AW = 32;
  localparam int WW = DW*NF+NNW+1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic nb_valid_i = 1'b0;
  logic [NNW-1:0] nb_size_i = '0;
  logic nb_last_i = 1'b0;
  logic feat_valid_i = 1'b0;
  logic [DW-1:0] feat_data_i = '0;

  logic nb_ready [2];
  logic feat_ready [2];
  logic ena [2];
  logic wea [2];
  logic whr [2];
  logic ovf [2];
  logic err [2];
  logic [WW-1:0] din [2];
  logic [AW-1:0] addra [2];
  logic [AW-1:0] rcnt [2];
`ifdef WH_PACKER_CHECKSUM_EN
  logic [31:0] csum [2];
`endif

  wh_bram_packer #(.BRAM_DEPTH(1024)) dut_big (
    .clk(clk), .rst(rst), .start_i(start_i),
    .nb_valid_i(nb_valid_i), .nb_size_i(nb_size_i), .nb_last_i(nb_last_i), .nb_ready_o(nb_ready[0]),
    .feat_valid_i(feat_valid_i), .feat_data_i(feat_data_i), .feat_ready_o(feat_ready[0]),
    .WH_BRAM_din(din[0]), .WH_BRAM_ena(ena[0]), .WH_BRAM_wea(wea[0]), .WH_BRAM_addra(addra[0]),
    .row_count_o(rcnt[0]), .wh_ready_o(whr[0]), .overflow_o(ovf[0]), .err_o(err[0])
`ifdef WH_PACKER_CHECKSUM_EN
    , .checksum_o(csum[0])
`endif
  );

  wh_bram_packer #(.BRAM_DEPTH(4)) dut_small (
    .clk(clk), .rst(rst), .start_i(start_i),
    .nb_valid_i(nb_valid_i), .nb_size_i(nb_size_i), .nb_last_i(nb_last_i), .nb_ready_o(nb_ready[1]),
    .feat_valid_i(feat_valid_i), .feat_data_i(feat_data_i), .feat_ready_o(feat_ready[1]),
    .WH_BRAM_din(din[1]), .WH_BRAM_ena(ena[1]), .WH_BRAM_wea(wea[1]), .WH_BRAM_addra(addra[1]),
    .row_count_o(rcnt[1]), .wh_ready_o(whr[1]), .overflow_o(ovf[1]), .err_o(err[1])
`ifdef WH_PACKER_CHECKSUM_EN
    , .checksum_o(csum[1])
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit rnd = 1'b0;

  int whr_cnt = 0;
  int err_cnt = 0;
  int wr_cnt [2] = '{0, 0};
  logic [31:0] cs_done = '0;
  logic [WW-1:0] mem [2][1024];

  typedef enum {P_IDLE, P_HDR, P_FEAT, P_WRITE, P_DONE} phase_t;
  phase_t ph = P_IDLE;
  int m_size = 0;
  int m_row = 0;
  int m_fcnt = 0;
  bit m_last = 1'b0;
  logic [DW-1:0] m_feat [NF];
  int m_addr [2] = '{0, 0};
  int m_rc [2] = '{0, 0};
  bit m_ovf [2] = '{1'b0, 1'b0};
  logic [31:0] m_csum = '0;

  function automatic int depth(input int d);
    return (d == 0) ? 1024 : 4;
  endfunction

  function automatic logic [WW-1:0] pack_word();
    logic [WW-1:0] w = '0;
    for (int k = 0; k < NF; k++) w[WW-1-DW*k -: DW] = m_feat[k];
    w[NNW:1] = NNW'(m_size);
    w[0] = (m_row == 0);
    return w;
  endfunction

  task automatic chk(input string nm, input int d, input logic [WW-1:0] act, input logic [WW-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h, expected %0h", nm, d, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    logic wr;
    logic [WW-1:0] exp_din;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        wr = (ph == P_WRITE) && (m_addr[d] < depth(d));
        exp_din = wr ? pack_word() : '0;
        chk("nb_ready", d, WW'(nb_ready[d]), WW'(ph == P_HDR));
        chk("feat_ready", d, WW'(feat_ready[d]), WW'(ph == P_FEAT));
        chk("ena", d, WW'(ena[d]), WW'(wr));
        chk("wea", d, WW'(wea[d]), WW'(wr));
        chk("din", d, din[d], exp_din);
        chk("addra", d, WW'(addra[d]), WW'(m_addr[d]));
        chk("row_count", d, WW'(rcnt[d]), WW'(m_rc[d]));
        chk("overflow", d, WW'(ovf[d]), WW'(m_ovf[d]));
        chk("wh_ready", d, WW'(whr[d]), WW'(ph == P_DONE));
        chk("err", d, WW'(err[d]), WW'((ph == P_HDR) && nb_valid_i && (nb_size_i == '0)));
`ifdef WH_PACKER_CHECKSUM_EN
        if (ph == P_DONE) chk("checksum", d, WW'(csum[d]), WW'(m_csum));
`endif
        if (ena[d] === 1'b1) begin
          mem[d][addra[d][9:0]] = din[d];
          wr_cnt[d]++;
        end
      end
      if (whr[0] === 1'b1) begin
        whr_cnt++;
`ifdef WH_PACKER_CHECKSUM_EN
        cs_done = csum[0];
`endif
      end
      if (err[0] === 1'b1) err_cnt++;
    end

    // advance the transaction model to what the next cycle must show
    if (rst) begin
      ph = P_IDLE;
      m_addr = '{0, 0};
      m_rc = '{0, 0};
      m_ovf = '{1'b0, 1'b0};
      m_csum = '0;
    end else begin
      case (ph)
        P_IDLE: if (start_i) begin
          ph = P_HDR;
          m_addr = '{0, 0};
          m_rc = '{0, 0};
          m_ovf = '{1'b0, 1'b0};
          m_csum = '0;
        end
        P_HDR: if (nb_valid_i) begin
          if (nb_size_i == '0) begin
            if (nb_last_i) ph = P_DONE;
          end else begin
            m_size = int'(nb_size_i);
            m_last = nb_last_i;
            m_row = 0;
            m_fcnt = 0;
            ph = P_FEAT;
          end
        end
        P_FEAT: if (feat_valid_i) begin
          m_feat[m_fcnt] = feat_data_i;
          m_csum = m_csum + 32'(feat_data_i);
          m_fcnt++;
          if (m_fcnt == NF) ph = P_WRITE;
        end
        P_WRITE: begin
          for (int d = 0; d < 2; d++) begin
            if (m_addr[d] < depth(d)) begin
              m_addr[d]++;
              m_rc[d]++;
            end else begin
              m_ovf[d] = 1'b1;
            end
          end
          if (m_row == m_size - 1) ph = m_last ? P_DONE : P_HDR;
          else begin
            m_row++;
            m_fcnt = 0;
            ph = P_FEAT;
          end
        end
        P_DONE: ph = P_IDLE;
        default: ph = P_IDLE;
      endcase
    end
  end

  task automatic wait_hs(input bit is_feat, input string nm);
    int n = 0;
    @(negedge clk);
    while (!(is_feat ? feat_ready[0] : nb_ready[0])) begin
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL timeout_%s: ready stayed low for 200 cycles, required a handshake", nm);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (whr[0] !== 1'b1) begin
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL timeout_wh_ready: no pulse within 200 cycles, required 1");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic send_hdr(input int sz, input bit last);
    nb_valid_i = 1'b1;
    nb_size_i = NNW'(sz);
    nb_last_i = last;
    if (rnd) begin
      feat_valid_i = 1'($urandom);
      feat_data_i = DW'($urandom);
    end
    wait_hs(1'b0, "hdr");
    nb_valid_i = 1'b0;
    nb_last_i = 1'b0;
    feat_valid_i = 1'b0;
  endtask

  // gap: 0 back-to-back, 1 valid low every other cycle, 2 random gaps
  task automatic send_row(input logic [DW-1:0] val, input bit rand_data, input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      if (gap == 1 || (gap == 2 && ($urandom % 3) == 0)) begin
        feat_valid_i = 1'b0;
        @(posedge clk);
        #1;
      end
      feat_valid_i = 1'b1;
      feat_data_i = rand_data ? DW'($urandom) : val;
      if (rnd) start_i = (($urandom % 4) == 0);
      wait_hs(1'b1, "feat");
    end
    feat_valid_i = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic clear_counts();
    whr_cnt = 0;
    err_cnt = 0;
    wr_cnt = '{0, 0};
  endtask

  task automatic two_group_frame(input int gap);
    logic [DW-1:0] g2 [5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1};
    clear_counts();
    start_frame();
    send_hdr(5, 1'b0);
    for (int r = 0; r < 5; r++) send_row(DW'(r + 1), 1'b0, NF, gap);
    send_hdr(5, 1'b1);
    for (int r = 0; r < 5; r++) send_row(g2[r], 1'b0, NF, gap);
    wait_done();
    @(posedge clk);
    #1;
    chk("frame_rows", 0, WW'(rcnt[0]), WW'(10));
    chk("frame_writes", 0, WW'(wr_cnt[0]), WW'(10));
    chk("frame_whr_pulses", 0, WW'(whr_cnt), WW'(1));
    chk("word0", 0, mem[0][0], {{16{8'h01}}, 8'h05, 1'b1});
    chk("word4", 0, mem[0][4], {{16{8'h05}}, 8'h05, 1'b0});
    chk("word5", 0, mem[0][5], {{16{8'h01}}, 8'h05, 1'b1});
    chk("word8", 0, mem[0][8], {{16{8'h04}}, 8'h05, 1'b0});
    chk("word9", 0, mem[0][9], {{16{8'h01}}, 8'h05, 1'b0});
`ifdef WH_PACKER_CHECKSUM_EN
    chk("checksum_416", 0, WW'(cs_done), WW'(416));
`endif
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    two_group_frame(0);
    two_group_frame(1);

    clear_counts();
    start_frame();
    send_hdr(0, 1'b0);
    send_hdr(1, 1'b1);
    send_row(8'hA5, 1'b0, NF, 0);
    wait_done();
    chk("err_pulses", 0, WW'(err_cnt), WW'(1));
    chk("err_writes", 0, WW'(wr_cnt[0]), WW'(1));
    chk("err_word0", 0, mem[0][0], {{16{8'hA5}}, 8'h01, 1'b1});

    clear_counts();
    start_frame();
    send_hdr(6, 1'b1);
    for (int r = 0; r < 6; r++) send_row(DW'(8'h10 + r), 1'b0, NF, 0);
    wait_done();
    chk("ovf_small_rows", 1, WW'(rcnt[1]), WW'(4));
    chk("ovf_small_flag", 1, WW'(ovf[1]), WW'(1));
    chk("ovf_small_writes", 1, WW'(wr_cnt[1]), WW'(4));
    chk("ovf_big_rows", 0, WW'(rcnt[0]), WW'(6));
    chk("ovf_whr_pulses", 0, WW'(whr_cnt), WW'(1));
    chk("ovf_small_word3", 1, mem[1][3], {{16{8'h13}}, 8'h06, 1'b0});

    clear_counts();
    start_frame();
    send_hdr(3, 1'b1);
    send_row(8'h21, 1'b0, NF, 0);
    send_row(8'h22, 1'b0, NF, 0);
    send_row(8'h23, 1'b0, 8, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_writes", 0, WW'(wr_cnt[0]), WW'(2));
    chk("rst_rows", 0, WW'(rcnt[0]), WW'(0));
    clear_counts();
    start_frame();
    send_hdr(1, 1'b1);
    send_row(8'h77, 1'b0, NF, 0);
    wait_done();
    chk("rst_new_writes", 0, WW'(wr_cnt[0]), WW'(1));
    chk("rst_new_word0", 0, mem[0][0], {{16{8'h77}}, 8'h01, 1'b1});

    rnd = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int ng;
      ng = int'($urandom_range(1, 3));
      start_frame();
      for (int g = 0; g < ng; g++) begin
        int sz;
        sz = int'($urandom_range(0, 4));
        send_hdr(sz, g == ng - 1);
        for (int r = 0; r < sz; r++) send_row('0, 1'b1, NF, 2);
      end
      wait_done();
      repeat (int'($urandom_range(0, 3))) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at 3 ms, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
